ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL set the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port imem_req, output, 1 bit, SHALL request an instruction word at imem_addr.
REQ-005 Port imem_addr, output, 32 bits, SHALL carry the word address of the request, equal to pc_out.
REQ-006 Port imem_ack, input, 1 bit, SHALL mark imem_rdata valid for the outstanding request.
REQ-007 Port imem_rdata, input, 32 bits, SHALL carry the fetched instruction word.
REQ-008 Port instr_valid, output, 1 bit, SHALL mark instr, imm16 and pc_out valid for the consumer.
REQ-009 Port instr_ready, input, 1 bit, SHALL be the consumer accept signal.
REQ-010 Port instr, output, 32 bits, SHALL hold the latched instruction.
REQ-011 Port imm16, output, 16 bits, SHALL equal instr[15:0] and drive the extend unit's immediate input.
REQ-012 Port pc_out, output, 32 bits, SHALL be the PC of the current fetch or held instruction.
REQ-013 Port npc_sel, input, 2 bits, SHALL select the next PC: 00 seq, 01 branch, 10 jump, 11 register.
REQ-014 Port ext_imm32, input, 32 bits, SHALL be the sign-extended branch offset from the extend unit.
REQ-015 Port rs_val, input, 32 bits, SHALL be the register-jump target.
REQ-016 Port fault, output, 1 bit, SHALL flag a misaligned next-PC.
REQ-017 Port fetch_cnt, output, 32 bits, SHALL count completed fetches.

Function
REQ-018 The FSM SHALL have three states: S_FETCH, S_HOLD and S_FAULT.
REQ-019 In S_FETCH, imem_req SHALL be 1 and SHALL remain 1 with imem_addr stable until imem_ack=1.
REQ-020 imem_ack may arrive in the same cycle as the first imem_req, or any later cycle; on imem_ack in S_FETCH the block SHALL latch instr<=imem_rdata, increment fetch_cnt and go to S_HOLD, all on the same edge.
REQ-021 In S_HOLD: instr_valid=1, imem_req=0, and instr, imm16 and pc_out SHALL stay stable until instr_ready=1.
REQ-022 imem_ack outside S_FETCH SHALL be ignored.
REQ-023 On an S_HOLD handshake (instr_valid & instr_ready), next PC SHALL be computed from npc_sel sampled in that cycle, with pc4 = pc_out+4:
- 00: pc4
- 01: pc4 + (ext_imm32<<2), mod 2^32
- 10: {pc4[31:28], instr[25:0], 2'b00}
- 11: rs_val
REQ-024 If next PC[1:0]==0, the block SHALL load it into the PC and enter S_FETCH; the new request asserts the next cycle, so handshake-to-next-req latency is 1 cycle.
REQ-025 If next PC[1:0]!=0, the block SHALL leave the PC unchanged and enter S_FAULT.
REQ-026 S_FAULT SHALL assert fault=1 with imem_req=0 and instr_valid=0, and be left only by reset.
REQ-027 PC arithmetic SHALL wrap modulo 2^32 with no flag (32'hFFFF_FFFC seq -> 32'h0000_0000).
REQ-028 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 npc_sel, ext_imm32 and rs_val SHALL be ignored outside the handshake cycle.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set:
- PC=RESET_PC
- state=S_FETCH
- instr=32'h0000_0000
- fetch_cnt=0
- fault=0
- instr_valid=0
REQ-031 Reset SHALL take priority over every other event, including an imem_ack in the same cycle, which is dropped.
REQ-032 Reset mid-fetch SHALL abandon the outstanding request; imem_req SHALL re-assert at RESET_PC in the first cycle after rst falls.

Verification
REQ-033 Reset release: imem_req=1, imem_addr=0x0000_3000, instr_valid=0, fetch_cnt=0 in the first cycle.
REQ-034 Ack after 2 wait cycles with rdata=0x2408_0005: instr_valid=1, imm16=0x0005, fetch_cnt=1; instr_ready held 0 for 3 cycles keeps outputs stable; then ready=1, npc_sel=00 gives the next req at 0x0000_3004.
REQ-035 Branch at pc 0x0000_3004, npc_sel=01, ext_imm32=0xFFFF_FFFF -> next imem_addr=0x0000_3004.
REQ-036 Jump at pc 0x0000_3008, instr=0x0800_0C10, npc_sel=10 -> next imem_addr=0x0000_3040.
REQ-037 npc_sel=11, rs_val=0x0000_3002 -> fault=1 next cycle, imem_req=0 and instr_valid=0 thereafter; rst -> fault=0, imem_addr=0x0000_3000.
REQ-038 rst=1 coincident with imem_ack during S_FETCH -> instr=0, fetch_cnt=0, instr_valid=0; imem_req=1 at 0x0000_3000 after rst falls.

Source files
------------

// File: rtl/ifu_if.sv
// Instruction fetch bus: memory request/response plus the held
// instruction handed to the decode consumer.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, imm16, pc_out,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, imm16, pc_out,
    output instr_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word, holds it for the consumer,
// then computes the next PC (seq/branch/jump/register) or faults.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  ifu_if.master       bus,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] ext_imm32,
  input  logic [31:0] rs_val,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_cnt;
  logic [31:0] w_pc4;
  logic [31:0] w_npc;
  logic        w_ld_instr;
  logic        w_ld_pc;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_npc = w_pc4;
    unique case (npc_sel)
      2'b00: w_npc = w_pc4;
      2'b01: w_npc = w_pc4 + {ext_imm32[29:0], 2'b00};
      2'b10: w_npc = {w_pc4[31:28], r_instr[25:0], 2'b00};
      2'b11: w_npc = rs_val;
      default: w_npc = w_pc4;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_ld_instr   = 1'b0;
    w_ld_pc      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_next_state = S_HOLD;
          w_ld_instr   = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          // misaligned target keeps the old PC for post-mortem
          if (w_npc[1:0] == 2'b00) begin
            w_next_state = S_FETCH;
            w_ld_pc      = 1'b1;
          end else begin
            w_next_state = S_FAULT;
          end
        end
      end
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_cnt   <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      if (w_ld_pc) begin
        r_pc <= w_npc;
      end
      if (w_ld_instr) begin
        r_instr <= bus.imem_rdata;
        r_cnt   <= r_cnt + 32'd1;
      end
    end
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == S_HOLD);
  assign bus.instr       = r_instr;
  assign bus.imm16       = r_instr[15:0];
  assign bus.pc_out      = r_pc;
  assign fault           = (r_state == S_FAULT);
  assign fetch_cnt       = r_cnt;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus randomized traffic checked
// against a transaction-level model of fetch/hold/fault behaviour.
module tb_ifu;
  logic        clk;
  logic        rst;
  logic [1:0]  npc_sel;
  logic [31:0] ext_imm32;
  logic [31:0] rs_val;
  logic        fault;
  logic [31:0] fetch_cnt;

  ifu_if bus ();

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .npc_sel   (npc_sel),
    .ext_imm32 (ext_imm32),
    .rs_val    (rs_val),
    .fault     (fault),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  bit          m_holding;
  bit          m_faulted;

  function automatic logic [31:0] ref_npc(input logic [31:0] pc,
                                          input logic [31:0] ins,
                                          input logic [1:0] sel,
                                          input logic [31:0] imm,
                                          input logic [31:0] rs);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    case (sel)
      2'b00: return pc4;
      2'b01: return pc4 + imm * 32'd4;
      2'b10: return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      default: return rs;
    endcase
  endfunction

  // drive one cycle at the negedge, advance model at posedge,
  // return at the next negedge with outputs settled
  task automatic step(input logic a_rst, input logic a_ack,
                      input logic [31:0] a_rdata, input logic a_rdy,
                      input logic [1:0] a_sel, input logic [31:0] a_imm,
                      input logic [31:0] a_rs);
    logic [31:0] n;
    rst = a_rst;
    bus.imem_ack = a_ack;
    bus.imem_rdata = a_rdata;
    bus.instr_ready = a_rdy;
    npc_sel = a_sel;
    ext_imm32 = a_imm;
    rs_val = a_rs;
    @(posedge clk);
    if (a_rst) begin
      m_pc = 32'h0000_3000;
      m_instr = 32'h0;
      m_cnt = 32'h0;
      m_holding = 0;
      m_faulted = 0;
    end else if (m_faulted) begin
      m_faulted = 1;
    end else if (!m_holding) begin
      if (a_ack) begin
        m_instr = a_rdata;
        m_cnt = m_cnt + 32'd1;
        m_holding = 1;
      end
    end else if (a_rdy) begin
      n = ref_npc(m_pc, m_instr, a_sel, a_imm, a_rs);
      m_holding = 0;
      if (n % 4 == 0) m_pc = n;
      else m_faulted = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'hDEAD_BEEF, 1, 2'b11, 0, 32'h1);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL reset_req: req=%b addr=%h want 1/00003000",
               bus.imem_req, bus.imem_addr);
    end
    n_checks++;
    if (bus.instr_valid !== 1'b0 || fetch_cnt !== 32'h0 ||
        fault !== 1'b0 || bus.instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b cnt=%h fault=%b instr=%h want 0",
               bus.instr_valid, fetch_cnt, fault, bus.instr);
    end
  endtask

  task automatic test_seq();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 32'h1111_1111, 1, 2'b11, 0, 32'h3);
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000 ||
          bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_wait%0d: req=%b addr=%h valid=%b", i,
                 bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    step(0, 1, 32'h2408_0005, 0, 0, 0, 0);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.imm16 !== 16'h0005 ||
        fetch_cnt !== 32'd1 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_ack: valid=%b imm16=%h cnt=%0d req=%b want 1/0005/1/0",
               bus.instr_valid, bus.imm16, fetch_cnt, bus.imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'hFFFF_FFFF, 0, 2'($urandom), $urandom, $urandom);
      n_checks++;
      if (bus.instr !== 32'h2408_0005 || bus.pc_out !== 32'h0000_3000 ||
          bus.instr_valid !== 1'b1 || fetch_cnt !== 32'd1) begin
        n_fail++;
        $display("FAIL seq_hold%0d: instr=%h pc=%h valid=%b cnt=%0d", i,
                 bus.instr, bus.pc_out, bus.instr_valid, fetch_cnt);
      end
    end
    step(0, 0, 0, 1, 2'b00, 32'h7, 32'h5);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3004 ||
        bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_next: req=%b addr=%h valid=%b want 1/00003004/0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_branch();
    step(0, 1, 32'h1000_FFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b01, 32'hFFFF_FFFF, 0);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3004) begin
      n_fail++;
      $display("FAIL branch: req=%b addr=%h want 1/00003004",
               bus.imem_req, bus.imem_addr);
    end
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 0, 0);
  endtask

  task automatic test_jump();
    n_checks++;
    if (bus.imem_addr !== 32'h0000_3008) begin
      n_fail++;
      $display("FAIL jump_pre: addr=%h want 00003008", bus.imem_addr);
    end
    step(0, 1, 32'h0800_0C10, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b10, 32'h1234, 32'h8);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3040) begin
      n_fail++;
      $display("FAIL jump: req=%b addr=%h want 1/00003040",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_fault();
    step(0, 1, 32'hABCD_0001, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b11, 0, 32'h0000_3002);
    n_checks++;
    if (fault !== 1'b1 || bus.imem_req !== 1'b0 ||
        bus.instr_valid !== 1'b0 || bus.pc_out !== 32'h0000_3040) begin
      n_fail++;
      $display("FAIL fault_enter: fault=%b req=%b valid=%b pc=%h",
               fault, bus.imem_req, bus.instr_valid, bus.pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h5555_5555, 1, 2'b00, 0, 0);
      n_checks++;
      if (fault !== 1'b1 || bus.imem_req !== 1'b0 ||
          bus.instr_valid !== 1'b0 || fetch_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL fault_stay%0d: fault=%b req=%b valid=%b cnt=%0d", i,
                 fault, bus.imem_req, bus.instr_valid, fetch_cnt);
      end
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (fault !== 1'b0 || bus.imem_addr !== 32'h0000_3000 ||
        bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b addr=%h req=%b",
               fault, bus.imem_addr, bus.imem_req);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b11, 0, 32'hFFFF_FFFC);
    step(0, 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'b00, 0, 0);
    n_checks++;
    if (bus.imem_addr !== 32'h0000_0000 || bus.imem_req !== 1'b1 ||
        fault !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h req=%b fault=%b want 0/1/0",
               bus.imem_addr, bus.imem_req, fault);
    end
  endtask

  task automatic test_reset_ack();
    n_checks++;
    if (fetch_cnt === 32'h0) begin
      n_fail++;
      $display("FAIL rst_ack_pre: cnt=%0d want nonzero", fetch_cnt);
    end
    step(1, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    n_checks++;
    if (bus.instr !== 32'h0 || fetch_cnt !== 32'h0 ||
        bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack: instr=%h cnt=%0d valid=%b want 0/0/0",
               bus.instr, fetch_cnt, bus.instr_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL rst_ack_req: req=%b addr=%h want 1/00003000",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic        r;
    logic [1:0]  s;
    logic [31:0] rs;
    logic [31:0] im;
    for (int i = 0; i < 400; i++) begin
      r  = m_faulted ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 39) == 0);
      s  = 2'($urandom);
      rs = $urandom;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      im = 32'($urandom_range(0, 63)) - 32'd32;
      step(r, 1'($urandom), $urandom, 1'($urandom), s, im, rs);
      n_checks++;
      if (bus.imem_req !== (!m_holding && !m_faulted) ||
          bus.instr_valid !== m_holding || fault !== m_faulted) begin
        n_fail++;
        $display("FAIL rand_ctl%0d: req=%b valid=%b fault=%b want %b/%b/%b",
                 i, bus.imem_req, bus.instr_valid, fault,
                 !m_holding && !m_faulted, m_holding, m_faulted);
      end
      n_checks++;
      if (bus.imem_addr !== m_pc || bus.pc_out !== m_pc ||
          bus.instr !== m_instr || bus.imm16 !== m_instr[15:0] ||
          fetch_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_dat%0d: pc=%h instr=%h cnt=%0d want %h/%h/%0d",
                 i, bus.pc_out, bus.instr, fetch_cnt, m_pc, m_instr, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    npc_sel = 2'b00;
    ext_imm32 = 32'h0;
    rs_val = 32'h0;
    m_pc = 32'h0;
    m_instr = 32'h0;
    m_cnt = 32'h0;
    m_holding = 0;
    m_faulted = 0;
    @(negedge clk);
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_fault();
    test_wrap();
    test_reset_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
